main_control_fsm: RTL and testbench

Multicycle main control unit for the SAMAB CPU datapath. It sequences each 16-bit instruction through fetch, decode, execute, memory and write-back states. It drives the 3-bit `ops` class code consumed by ALU control, plus all datapath enables and muxes, and stalls on a req/ready memory handshake. It sits between the instruction register opcode field and the datapath, upstream of ALU control.

---
 rtl/cpu_ctrl_pkg.sv | 35 +++
 rtl/ctrl_output_decode.sv | 84 ++++++++
 rtl/main_control_fsm.sv | 82 ++++++++
 tb/tb_main_control_fsm.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: opcodes, state encoding and datapath select encodings for the SAMAB control unit
package cpu_ctrl_pkg;
  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0001;
  localparam logic [3:0] OP_LW    = 4'b0010;
  localparam logic [3:0] OP_SW    = 4'b0011;
  localparam logic [3:0] OP_BEQ   = 4'b0100;
  localparam logic [3:0] OP_J     = 4'b0101;
  localparam logic [3:0] OP_HALT  = 4'b1111;
  localparam logic [2:0] OPS_ADD   = 3'b001;
  localparam logic [2:0] OPS_SUB   = 3'b010;
  localparam logic [2:0] OPS_RTYPE = 3'b100;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MADDR, S_MRD,
    S_MWR, S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP, S_HALT
  } state_t;
  // Undefined opcodes fall back to FETCH; the caller flags them as illegal.
  function automatic state_t decode_next(input logic [3:0] op);
    case (op)
      OP_RTYPE:    return S_EXEC_R;
      OP_ADDI:     return S_EXEC_I;
      OP_LW, OP_SW: return S_MADDR;
      OP_BEQ:      return S_BRANCH;
      OP_J:        return S_JUMP;
      OP_HALT:     return S_HALT;
      default:     return S_FETCH;
    endcase
  endfunction
endpackage

// File: rtl/ctrl_output_decode.sv
// ctrl_output_decode: maps the control state (plus mem_ready/zero Mealy terms) to datapath controls
module ctrl_output_decode
  import cpu_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic       mem_ready,
  input  logic       zero,
  output logic [2:0] ops,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       halted
);
  always_comb begin
    ops        = OPS_ADD;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    halted     = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_ONE;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: alu_src_b = SRCB_IMM;
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        ops       = OPS_RTYPE;
      end
      S_EXEC_I, S_MADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
      end
      S_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_WB_I: reg_write = 1'b1;
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        ops       = OPS_SUB;
        pc_src    = PC_ALUOUT;
        pc_write  = zero;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = PC_JUMP;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: rtl/main_control_fsm.sv
// main_control_fsm: multicycle fetch/decode/execute/memory/write-back sequencer for the SAMAB CPU
module main_control_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           mem_ready,
  output logic [2:0]     ops,
  output logic           mem_req,
  output logic           mem_we,
  output logic           iord,
  output logic           ir_write,
  output logic           pc_write,
  output logic [1:0]     pc_src,
  output logic           alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic           reg_write,
  output logic           reg_dst,
  output logic           mem_to_reg,
  output logic           halted,
  output logic           illegal
);
  state_t state_q, state_d;
  logic   is_sw_q, is_sw_d;
  logic   illegal_q, illegal_d;
  // The load/store choice is captured in DECODE so MADDR never looks at the opcode again.
  always_comb begin
    state_d   = state_q;
    is_sw_d   = is_sw_q;
    illegal_d = 1'b0;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        state_d   = decode_next(opcode[3:0]);
        is_sw_d   = opcode[3:0] == OP_SW;
        illegal_d = decode_next(opcode[3:0]) == S_FETCH;
      end
      S_EXEC_R: state_d = S_WB_R;
      S_EXEC_I: state_d = S_WB_I;
      S_MADDR:  state_d = is_sw_q ? S_MWR : S_MRD;
      S_MRD:    state_d = mem_ready ? S_WB_MEM : S_MRD;
      S_MWR:    state_d = mem_ready ? S_FETCH : S_MWR;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      is_sw_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_sw_q   <= is_sw_d;
      illegal_q <= illegal_d;
    end
  end
  assign illegal = illegal_q;
  ctrl_output_decode u_dec (
    .state      (state_q),
    .mem_ready  (mem_ready),
    .zero       (zero),
    .ops        (ops),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .halted     (halted)
  );
endmodule

// File: tb/tb_main_control_fsm.sv
// tb_main_control_fsm: per-instruction cycle plans built from the instruction timing tables, checked every cycle
module tb_main_control_fsm;
  logic clk = 1'b0, rst = 1'b1, zero = 1'b0, mem_ready = 1'b0;
  logic [3:0] opcode = 4'd0;
  logic [2:0] ops;
  logic [1:0] pc_src, alu_src_b;
  logic mem_req, mem_we, iord, ir_write, pc_write, alu_src_a;
  logic reg_write, reg_dst, mem_to_reg, halted, illegal;
  logic [17:0] dut_v;
  always #5 clk = ~clk;
  main_control_fsm #(.OPW(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .ops(ops), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .halted(halted), .illegal(illegal)
  );
  assign dut_v = {ops, mem_req, mem_we, iord, ir_write, pc_write, pc_src,
                  alu_src_a, alu_src_b, reg_write, reg_dst, mem_to_reg, halted, illegal};
  typedef struct packed {
    logic        rdy;
    logic        z;
    logic [3:0]  op;
    logic [17:0] exp;
  } step_t;
  step_t q[$];
  string tq[$];
  int checks = 0, errors = 0;
  logic il_prev = 1'b0;
  function automatic logic [17:0] ov(input logic [2:0] o, input logic rq, we, io, irw, pcw,
                                     input logic [1:0] ps, input logic a, input logic [1:0] b,
                                     input logic rw, rd, m2r, h, il);
    return {o, rq, we, io, irw, pcw, ps, a, b, rw, rd, m2r, h, il};
  endfunction
  function automatic logic r1();
    return 1'($urandom_range(0, 1));
  endfunction
  function automatic logic [3:0] r4();
    return 4'($urandom_range(0, 15));
  endfunction
  function automatic logic [17:0] fetch_v(input logic done, input logic il);
    return ov(3'b001, 1, 0, 0, done, done, 2'b00, 0, 2'b01, 0, 0, 0, 0, il);
  endfunction
  function automatic logic [17:0] idle_v();
    return ov(3'b001, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [17:0] halt_v();
    return ov(3'b001, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0, 1, 0);
  endfunction
  task automatic check(input logic [17:0] exp, input string tag);
    checks++;
    assert (dut_v === exp) else begin
      errors++;
      $error("FAIL %s got %h want %h", tag, dut_v, exp);
    end
  endtask
  task automatic push(input logic rdy, z, input logic [3:0] op, input logic [17:0] exp, input string tag);
    q.push_back('{rdy, z, op, exp});
    tq.push_back(tag);
  endtask
  task automatic run();
    step_t s;
    string t;
    while (q.size() > 0) begin
      s = q.pop_front();
      t = tq.pop_front();
      mem_ready = s.rdy;
      zero = s.z;
      opcode = s.op;
      #2;
      check(s.exp, t);
      @(posedge clk);
      #1;
    end
  endtask
  // Builds the expected cycle-by-cycle outputs of one instruction starting in FETCH.
  task automatic plan(input logic [3:0] op, input int zsel);
    int w;
    logic z;
    w = $urandom_range(0, 2);
    for (int i = 0; i < w; i++) push(1'b0, r1(), op, fetch_v(0, il_prev && i == 0), "fetch_wait");
    push(1'b1, r1(), op, fetch_v(1, il_prev && w == 0), "fetch");
    il_prev = 1'b0;
    push(r1(), r1(), op, ov(3'b001, 0, 0, 0, 0, 0, 2'b00, 0, 2'b10, 0, 0, 0, 0, 0), "decode");
    case (op)
      4'd0: begin
        push(r1(), r1(), r4(), ov(3'b100, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 0, 0, 0, 0, 0), "exec_r");
        push(r1(), r1(), r4(), ov(3'b001, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 1, 0, 0, 0), "wb_r");
      end
      4'd1: begin
        push(r1(), r1(), r4(), ov(3'b001, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 0, 0, 0, 0, 0), "exec_i");
        push(r1(), r1(), r4(), ov(3'b001, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 0, 0, 0, 0), "wb_i");
      end
      4'd2, 4'd3: begin
        push(r1(), r1(), r4(), ov(3'b001, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 0, 0, 0, 0, 0), "maddr");
        w = $urandom_range(0, 2);
        for (int i = 0; i <= w; i++)
          push(i == w, r1(), r4(), ov(3'b001, 1, op == 4'd3, 1, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0),
               op == 4'd3 ? "mwr" : "mrd");
        if (op == 4'd2)
          push(r1(), r1(), r4(), ov(3'b001, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 0, 1, 0, 0), "wb_mem");
      end
      4'd4: begin
        z = zsel < 0 ? r1() : zsel[0];
        push(r1(), z, r4(), ov(3'b010, 0, 0, 0, 0, z, 2'b01, 1, 2'b00, 0, 0, 0, 0, 0), "branch");
      end
      4'd5: push(r1(), r1(), r4(), ov(3'b001, 0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 0, 0, 0, 0, 0), "jump");
      4'd15: for (int i = 0; i < 10; i++) push(r1(), r1(), r4(), halt_v(), "halt");
      default: il_prev = 1'b1;
    endcase
    run();
  endtask
  initial begin
    int r;
    @(posedge clk);
    #1;
    check(idle_v(), "reset_idle");
    @(posedge clk);
    #1;
    rst = 1'b0;
    check(idle_v(), "idle_after_release");
    @(posedge clk);
    #1;
    plan(4'd0, -1);
    plan(4'd1, -1);
    plan(4'd2, -1);
    plan(4'd3, -1);
    plan(4'd4, 1);
    plan(4'd4, 0);
    plan(4'd5, -1);
    plan(4'd7, -1);
    plan(4'd0, -1);
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 7);
      plan(r < 6 ? 4'(r) : 4'($urandom_range(6, 14)), -1);
    end
    plan(4'd15, -1);
    rst = 1'b1;
    mem_ready = r1();
    #2;
    check(halt_v(), "halt_with_rst");
    @(posedge clk);
    #1;
    check(idle_v(), "halt_reset_idle");
    rst = 1'b0;
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    #2;
    check(fetch_v(0, 0), "fetch_hold0");
    @(posedge clk);
    #1;
    check(fetch_v(0, 0), "fetch_hold1");
    rst = 1'b1;
    @(posedge clk);
    #1;
    check(idle_v(), "rst_mid_fetch");
    rst = 1'b0;
    @(posedge clk);
    #1;
    plan(4'd3, -1);
    plan(4'd2, -1);
    plan(4'd9, -1);
    plan(4'd1, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
